// File: rtl/pipeline_stall_controller_if.sv
// Hazard/memory handshake inputs and per-stage pipeline controls of the stall sequencer.
// Pure wiring bundle, no latency of its own.
// No backpressure: each signal is a per-cycle level.
interface pipeline_stall_controller_if #(
    parameter int STALL_CNT_W = 16
);
    logic                   load_use_hazard;
    logic                   branch_taken;
    logic                   imem_ready;
    logic                   dmem_req;
    logic                   dmem_ready;
    logic                   pc_write;
    logic                   if_id_write;
    logic                   if_id_flush;
    logic                   id_ex_write;
    logic                   id_ex_bubble;
    logic                   ex_mem_write;
    logic                   mem_wb_bubble;
    logic                   mem_timeout;
    logic [STALL_CNT_W-1:0] stall_cycles;

    // Pipeline side: drives hazard and memory status, consumes the controls.
    modport master (
        output load_use_hazard, branch_taken, imem_ready, dmem_req, dmem_ready,
        input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
        input  ex_mem_write, mem_wb_bubble, mem_timeout, stall_cycles
    );

    // Controller side.
    modport slave (
        input  load_use_hazard, branch_taken, imem_ready, dmem_req, dmem_ready,
        output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
        output ex_mem_write, mem_wb_bubble, mem_timeout, stall_cycles
    );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline with data-memory wait FSM and stall counter.
// Controls are a combinational decode of state and inputs (zero added latency).
// A pending data access freezes every stage until dmem_ready or the wait timeout releases it.
module pipeline_stall_controller #(
    parameter int MEM_TIMEOUT = 15,
    parameter int STALL_CNT_W = 16
) (
    input logic                       clk,
    input logic                       rst_n,
    pipeline_stall_controller_if.slave ctl
);

    typedef enum logic {RUN, MEM_WAIT} fsm_t;

    localparam logic [7:0] TIMEOUT_V = 8'(MEM_TIMEOUT);

    fsm_t                   fsm;
    fsm_t                   fsm_nxt;
    logic [7:0]             wait_cnt;
    logic [7:0]             wait_nxt;
    logic                   timeout_set;
    logic                   freeze;
    logic                   mem_timeout_q;
    logic [STALL_CNT_W-1:0] stall_q;

    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_bubble;
    logic ex_mem_write;
    logic mem_wb_bubble;

    // Next-state for the memory wait FSM and priority decode of the stage controls.
    always_comb begin
        fsm_nxt       = fsm;
        wait_nxt      = wait_cnt;
        timeout_set   = 1'b0;
        freeze        = 1'b0;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_write  = 1'b1;
        mem_wb_bubble = 1'b0;

        case (fsm)
            RUN: begin
                if (ctl.dmem_req && !ctl.dmem_ready) begin
                    freeze   = 1'b1;
                    fsm_nxt  = MEM_WAIT;
                    wait_nxt = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (!ctl.dmem_ready && (wait_cnt < TIMEOUT_V)) begin
                    freeze   = 1'b1;
                    wait_nxt = wait_cnt + 8'd1;
                end else begin
                    // Release cycle: either the access completed or the wait gave up.
                    fsm_nxt     = RUN;
                    wait_nxt    = 8'd0;
                    timeout_set = !ctl.dmem_ready;
                end
            end
            default: begin
                fsm_nxt  = RUN;
                wait_nxt = 8'd0;
            end
        endcase

        // Upstream hazards are held stable while frozen, so they act on the release cycle.
        if (freeze) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (ctl.branch_taken) begin
            pc_write     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (ctl.load_use_hazard) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (!ctl.imem_ready) begin
            pc_write    = 1'b0;
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
        end

        // During reset fill the front end with NOPs and hold the PC.
        if (!rst_n) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_write   = 1'b1;
            id_ex_bubble  = 1'b1;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
        end
    end

    // State register, sticky timeout flag and saturating stall counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm           <= RUN;
            wait_cnt      <= 8'd0;
            mem_timeout_q <= 1'b0;
            stall_q       <= '0;
        end else begin
            fsm      <= fsm_nxt;
            wait_cnt <= wait_nxt;
            if (timeout_set) begin
                mem_timeout_q <= 1'b1;
            end
            if (!pc_write && (stall_q != {STALL_CNT_W{1'b1}})) begin
                stall_q <= stall_q + STALL_CNT_W'(1);
            end
        end
    end

    assign ctl.pc_write      = pc_write;
    assign ctl.if_id_write   = if_id_write;
    assign ctl.if_id_flush   = if_id_flush;
    assign ctl.id_ex_write   = id_ex_write;
    assign ctl.id_ex_bubble  = id_ex_bubble;
    assign ctl.ex_mem_write  = ex_mem_write;
    assign ctl.mem_wb_bubble = mem_wb_bubble;
    assign ctl.mem_timeout   = mem_timeout_q;
    assign ctl.stall_cycles  = stall_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for the stall sequencer: expected controls queued at drive time, checked mid-cycle.
// Registered state (stall count, timeout flag) checked just after each rising edge.
// Inputs are levels, so there is no backpressure to model.
module tb_pipeline_stall_controller;

    localparam int TO  = 4;
    localparam int SCW = 4;

    // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write, mem_wb_bubble}
    localparam logic [6:0] DEF = 7'b1101010;
    localparam logic [6:0] RST = 7'b0111101;
    localparam logic [6:0] FRZ = 7'b0000001;
    localparam logic [6:0] BR  = 7'b1111110;
    localparam logic [6:0] LU  = 7'b0001110;
    localparam logic [6:0] IMW = 7'b0111010;

    typedef struct {
        logic [6:0] ctrl;
        string      tag;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    int             total = 0;
    int             bad = 0;
    logic [SCW-1:0] exp_stall = '0;
    exp_t           sb[$];

    pipeline_stall_controller_if #(.STALL_CNT_W(SCW)) bus ();

    pipeline_stall_controller #(
        .MEM_TIMEOUT (TO),
        .STALL_CNT_W (SCW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (bus)
    );

    always #5 clk = ~clk;

    // One cycle: drive at posedge+1, compare controls at negedge, compare state after the next edge.
    task automatic step(input logic r, input logic luh, input logic br, input logic imr,
                        input logic dreq, input logic drdy, input logic [6:0] ec,
                        input logic eto, input string tag);
        exp_t       e;
        logic [6:0] obs;
        rst_n               = r;
        bus.load_use_hazard = luh;
        bus.branch_taken    = br;
        bus.imem_ready      = imr;
        bus.dmem_req        = dreq;
        bus.dmem_ready      = drdy;
        e.ctrl = ec;
        e.tag  = tag;
        sb.push_back(e);

        @(negedge clk);
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL %s scoreboard: no expected entry", tag);
        end else begin
            e   = sb.pop_front();
            obs = {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_write,
                   bus.id_ex_bubble, bus.ex_mem_write, bus.mem_wb_bubble};
            assert (obs === e.ctrl) else begin
                bad++;
                $error("FAIL %s ctrl: got %b want %b", e.tag, obs, e.ctrl);
            end
        end

        if (!r) begin
            exp_stall = '0;
        end else if (!ec[6] && (exp_stall != {SCW{1'b1}})) begin
            exp_stall = exp_stall + 1'b1;
        end

        @(posedge clk);
        #1;
        total++;
        assert (bus.stall_cycles === exp_stall) else begin
            bad++;
            $error("FAIL %s stall_cycles: got %0d want %0d", tag, bus.stall_cycles, exp_stall);
        end
        total++;
        assert (bus.mem_timeout === eto) else begin
            bad++;
            $error("FAIL %s mem_timeout: got %b want %b", tag, bus.mem_timeout, eto);
        end
    endtask

    initial begin
        rst_n               = 1'b0;
        bus.load_use_hazard = 1'b0;
        bus.branch_taken    = 1'b0;
        bus.imem_ready      = 1'b1;
        bus.dmem_req        = 1'b1;
        bus.dmem_ready      = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with a pending data access
        step(0, 0, 0, 1, 1, 0, RST, 0, "reset0");
        step(0, 0, 0, 1, 1, 0, RST, 0, "reset1");
        step(1, 0, 0, 1, 0, 0, DEF, 0, "idle");

        // Single-cycle hazards and priority
        step(1, 1, 0, 1, 0, 0, LU,  0, "load_use");
        step(1, 0, 0, 1, 0, 0, DEF, 0, "after_lu");
        step(1, 1, 1, 0, 0, 0, BR,  0, "branch_prio");
        step(1, 0, 0, 0, 0, 0, IMW, 0, "imem_wait");
        step(1, 0, 0, 1, 1, 1, DEF, 0, "zero_wait");

        // Three wait cycles then completion
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 1, 0, FRZ, 0, "dwait");
        step(1, 0, 0, 1, 1, 1, DEF, 0, "dwait_release");
        step(1, 0, 0, 1, 0, 0, DEF, 0, "dwait_run");

        // Held hazards act on the release cycle; freeze beats branch
        step(1, 1, 1, 1, 1, 0, FRZ, 0, "frz_over_branch");
        step(1, 1, 1, 1, 1, 1, BR,  0, "rel_branch");
        step(1, 1, 0, 1, 1, 0, FRZ, 0, "frz_over_lu");
        step(1, 1, 0, 1, 1, 1, LU,  0, "rel_lu");
        step(1, 0, 0, 0, 1, 0, FRZ, 0, "frz_over_imem");
        step(1, 0, 0, 0, 1, 1, IMW, 0, "rel_imem");

        // Reset while waiting returns to RUN without a timeout
        step(1, 0, 0, 1, 1, 0, FRZ, 0, "pre_rst_wait");
        step(0, 0, 0, 1, 1, 0, RST, 0, "rst_in_wait");
        step(1, 0, 0, 1, 0, 0, DEF, 0, "run_after_rst");

        // Completion exactly at the timeout boundary is not a timeout
        for (int i = 0; i < TO; i++) step(1, 0, 0, 1, 1, 0, FRZ, 0, "edge_wait");
        step(1, 0, 0, 1, 1, 1, DEF, 0, "edge_release");
        step(1, 0, 0, 1, 0, 0, DEF, 0, "edge_run");

        // Timeout: forced release, sticky flag until reset
        for (int i = 0; i < TO; i++) step(1, 0, 0, 1, 1, 0, FRZ, 0, "to_wait");
        step(1, 0, 0, 1, 1, 0, DEF, 1, "to_release");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, 0, DEF, 1, "to_sticky");
        step(0, 0, 0, 1, 0, 0, RST, 0, "to_clear");

        // Saturating stall counter
        for (int i = 0; i < 20; i++) step(1, 1, 0, 1, 0, 0, LU, 0, "sat");
        step(1, 0, 0, 1, 0, 0, DEF, 0, "sat_hold");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
